sar_search_8bit: RTL and testbench



---
 rtl/sar_search_pkg.sv | 22 ++
 rtl/sar_midpoint.sv | 52 +++++
 rtl/sar_search_8bit.sv | 175 +++++++++++++++++
 tb/tb_sar_search_8bit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_search_pkg.sv
// Shared definitions for the SAR binary-search initiator.
//   SAR_WIDTH   : default operand width
//   max_probes  : worst-case probe count for a given width (WIDTH+1)
//   MAX_PROBES  : worst-case probe count at the default width
//   sar_state_t : IDLE / PROBE / DONE state encoding
package sar_search_pkg;

  localparam int SAR_WIDTH = 8;

  function automatic int max_probes(input int w);
    return w + 1;
  endfunction

  localparam int MAX_PROBES = max_probes(SAR_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } sar_state_t;

endpackage

// File: rtl/sar_midpoint.sv
// Combinational bound update and midpoint for the SAR search.
// Ports:
//   lo, hi    : current search bounds
//   probe     : value currently under comparison
//   init      : load the full range (0 .. 2^WIDTH-1) instead of narrowing
//   go_lower  : key is below probe (narrow hi), otherwise narrow lo
//   lo_upd    : bound after update
//   hi_upd    : bound after update
//   mid_upd   : midpoint of the updated bounds (next probe)
//   at_lo     : probe sits on the lower bound (no room to go lower)
//   at_hi     : probe sits on the upper bound (no room to go higher)
module sar_midpoint
  import sar_search_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] probe,
  input  logic             init,
  input  logic             go_lower,
  output logic [WIDTH-1:0] lo_upd,
  output logic [WIDTH-1:0] hi_upd,
  output logic [WIDTH-1:0] mid_upd,
  output logic             at_lo,
  output logic             at_hi
);

  logic [WIDTH:0] sum;

  // probe-1 / probe+1 may wrap at the range ends; the caller terminates
  // the search on at_lo / at_hi before such a value would be used.
  always_comb begin
    lo_upd = lo;
    hi_upd = hi;
    if (init) begin
      lo_upd = '0;
      hi_upd = '1;
    end else if (go_lower) begin
      hi_upd = probe - WIDTH'(1);
    end else begin
      lo_upd = probe + WIDTH'(1);
    end
  end

  // One extra bit keeps lo+hi from overflowing before the halving.
  assign sum     = {1'b0, lo_upd} + {1'b0, hi_upd};
  assign mid_upd = WIDTH'(sum >> 1);
  assign at_lo   = (probe == lo);
  assign at_hi   = (probe == hi);

endmodule

// File: rtl/sar_search_8bit.sv
// Sequential binary-search initiator driving an external magnitude
// comparator. On start it probes midpoints of a shrinking [lo, hi] range,
// consuming lt/gt/eq verdicts, and reports the located key.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a search (accepted only in IDLE)
//   probe        : value presented to the comparator (registered)
//   probe_valid  : probe awaits a verdict
//   cmp_valid    : verdict valid; cmp_lt / cmp_gt / cmp_eq one-hot verdict
//   result       : located key, valid with done
//   found        : search hit, valid with done
//   err          : illegal verdict seen, valid with done
//   done         : one-cycle completion pulse
//   busy         : high while probing and during the done cycle
module sar_search_8bit
  import sar_search_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  output logic             probe_valid,
  input  logic             cmp_valid,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err,
  output logic             done,
  output logic             busy
);

  localparam int LIMIT = max_probes(WIDTH);
  localparam int CNT_W = $clog2(LIMIT + 1);

  sar_state_t       state, state_n;
  logic [WIDTH-1:0] lo, hi, lo_n, hi_n;
  logic [WIDTH-1:0] probe_n, result_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pv_n, found_n, err_n, done_n, busy_n;

  logic [WIDTH-1:0] lo_upd, hi_upd, mid_upd;
  logic             at_lo, at_hi, at_limit;
  logic [2:0]       verdict;

  sar_midpoint #(.WIDTH(WIDTH)) u_midpoint (
    .lo       (lo),
    .hi       (hi),
    .probe    (probe),
    .init     (state == ST_IDLE),
    .go_lower (cmp_lt),
    .lo_upd   (lo_upd),
    .hi_upd   (hi_upd),
    .mid_upd  (mid_upd),
    .at_lo    (at_lo),
    .at_hi    (at_hi)
  );

  assign verdict  = {cmp_lt, cmp_gt, cmp_eq};
  // The bounds collapse to a single value by probe WIDTH+1, so this guard
  // never fires in a legal search; it bounds the counter unconditionally.
  assign at_limit = (cnt >= CNT_W'(LIMIT));

  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    cnt_n    = cnt;
    probe_n  = probe;
    pv_n     = probe_valid;
    result_n = result;
    found_n  = found;
    err_n    = err;
    done_n   = 1'b0;
    busy_n   = busy;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_PROBE;
          lo_n     = lo_upd;
          hi_n     = hi_upd;
          probe_n  = mid_upd;
          pv_n     = 1'b1;
          busy_n   = 1'b1;
          cnt_n    = CNT_W'(1);
          result_n = '0;
          found_n  = 1'b0;
          err_n    = 1'b0;
        end
      end

      ST_PROBE: begin
        if (cmp_valid) begin
          // Default is to finish; legal narrowing verdicts override below.
          state_n = ST_DONE;
          pv_n    = 1'b0;
          done_n  = 1'b1;
          case (verdict)
            3'b001: begin
              result_n = probe;
              found_n  = 1'b1;
            end
            3'b100: begin
              if (!at_lo && !at_limit) begin
                state_n = ST_PROBE;
                pv_n    = 1'b1;
                done_n  = 1'b0;
                hi_n    = hi_upd;
                probe_n = mid_upd;
                cnt_n   = cnt + CNT_W'(1);
              end
            end
            3'b010: begin
              if (!at_hi && !at_limit) begin
                state_n = ST_PROBE;
                pv_n    = 1'b1;
                done_n  = 1'b0;
                lo_n    = lo_upd;
                probe_n = mid_upd;
                cnt_n   = cnt + CNT_W'(1);
              end
            end
            default: err_n = 1'b1;
          endcase
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = ST_IDLE;
        pv_n    = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      probe       <= '0;
      probe_valid <= 1'b0;
      result      <= '0;
      found       <= 1'b0;
      err         <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      probe       <= probe_n;
      probe_valid <= pv_n;
      result      <= result_n;
      found       <= found_n;
      err         <= err_n;
      done        <= done_n;
      busy        <= busy_n;
    end
  end

  // Bounds are always reloaded when a search starts, so they need no reset.
  always_ff @(posedge clk) begin
    lo <= lo_n;
    hi <= hi_n;
  end

endmodule

// File: tb/tb_sar_search_8bit.sv
// Directed bench for sar_search_8bit: a behavioural comparator environment,
// a plain-arithmetic binary-search model, and a per-cycle compare process.
module tb_sar_search_8bit;
  import sar_search_pkg::*;

  localparam int MODE_KEY     = 0;
  localparam int MODE_ALLGT   = 1;
  localparam int MODE_ILLEGAL = 2;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] probe, result;
  logic       probe_valid, cmp_valid, cmp_lt, cmp_gt, cmp_eq;
  logic       found, err, done, busy;

  always #5 clk = ~clk;

  sar_search_8bit #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .probe       (probe),
    .probe_valid (probe_valid),
    .cmp_valid   (cmp_valid),
    .cmp_lt      (cmp_lt),
    .cmp_gt      (cmp_gt),
    .cmp_eq      (cmp_eq),
    .result      (result),
    .found       (found),
    .err         (err),
    .done        (done),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] key = 8'h00;
  int         mode = MODE_KEY;
  int         wait_cycles = 0;
  int         wait_cnt = 0;
  int         verdict_idx = 0;

  logic [7:0] exp_probes[$];
  logic [7:0] lit_q[$];
  logic       exp_found, exp_err;
  logic [7:0] exp_result;
  bit         checking = 1'b0;
  int         pidx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Comparator environment: verdict delayed by wait_cycles per probe.
  always @(posedge clk) begin
    if (probe_valid && !cmp_valid) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
    if (!busy)                           verdict_idx <= 0;
    else if (probe_valid && cmp_valid)   verdict_idx <= verdict_idx + 1;
  end

  always_comb begin
    cmp_valid = probe_valid && (wait_cnt >= wait_cycles);
    cmp_lt    = (key < probe);
    cmp_gt    = (key > probe);
    cmp_eq    = (key == probe);
    if (mode == MODE_ALLGT) begin
      cmp_lt = 1'b0; cmp_gt = 1'b1; cmp_eq = 1'b0;
    end else if (mode == MODE_ILLEGAL && verdict_idx == 1) begin
      cmp_lt = 1'b1; cmp_gt = 1'b1; cmp_eq = 1'b0;
    end
  end

  // Reference: textbook binary search over integers.
  task automatic build_model(input logic [7:0] k, input int m);
    int lo, hi, p;
    bit lt_v, gt_v;
    lo = 0; hi = 255;
    exp_probes.delete();
    exp_found = 1'b0; exp_err = 1'b0; exp_result = 8'h00;
    for (int i = 0; i < 32; i++) begin
      p = (lo + hi) / 2;
      exp_probes.push_back(8'(p));
      if (m == MODE_ILLEGAL && i == 1) begin
        exp_err = 1'b1;
        break;
      end
      lt_v = (m == MODE_ALLGT) ? 1'b0 : (int'(k) < p);
      gt_v = (m == MODE_ALLGT) ? 1'b1 : (int'(k) > p);
      if (!lt_v && !gt_v) begin
        exp_found = 1'b1; exp_result = 8'(p);
        break;
      end
      if (lt_v) begin
        if (p == lo) break;
        hi = p - 1;
      end else begin
        if (p == hi) break;
        lo = p + 1;
      end
    end
  endtask

  task automatic pin_model(input string tag);
    check({tag, "_len"}, 32'(exp_probes.size()), 32'(lit_q.size()));
    for (int i = 0; i < lit_q.size() && i < exp_probes.size(); i++)
      check($sformatf("%s_p%0d", tag, i), 32'(exp_probes[i]), 32'(lit_q[i]));
  endtask

  // Per-cycle compare against the model while a search is in flight.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        if (probe_valid) begin
          if (pidx >= exp_probes.size() || pidx >= MAX_PROBES)
            check("probe_count", 32'(pidx), 32'(exp_probes.size() - 1));
          else
            check($sformatf("probe[%0d]", pidx), 32'(probe), 32'(exp_probes[pidx]));
          check("busy_probing", 32'(busy), 32'd1);
          if (cmp_valid) pidx++;
        end
        if (done) begin
          check("result", 32'(result), 32'(exp_result));
          check("found", 32'(found), 32'(exp_found));
          check("err", 32'(err), 32'(exp_err));
          check("probes_used", 32'(pidx), 32'(exp_probes.size()));
          check("busy_done", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic run_search(input logic [7:0] k, input int m, input int waits,
                            input bit poke, input int exp_cyc, input string tag);
    bit got;
    build_model(k, m);
    key = k; mode = m; wait_cycles = waits; pidx = 0;
    @(posedge clk); #1;
    checking = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        check({tag, "_done_cycle"}, 32'(c), 32'(exp_cyc));
        start = poke;            // must be ignored in the done cycle
      end else if (poke) begin
        start = (c % 5 == 2);    // must be ignored while probing
      end
    end
    if (!got) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checking = 1'b0;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_pv"}, 32'(probe_valid), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_hold_result"}, 32'(result), 32'(exp_result));
    check({tag, "_hold_found"}, 32'(found), 32'(exp_found));
    check({tag, "_hold_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_probe", 32'(probe), 32'd0);
    check("rst_pv", 32'(probe_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Pin the model to hand-derived probe sequences.
    build_model(8'h5A, MODE_KEY);
    lit_q = '{8'h7F, 8'h3F, 8'h5F, 8'h4F, 8'h57, 8'h5B, 8'h59, 8'h5A};
    pin_model("model_5a");
    build_model(8'hFF, MODE_KEY);
    lit_q = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFF};
    pin_model("model_ff");
    build_model(8'h00, MODE_KEY);
    lit_q = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    pin_model("model_00");
    build_model(8'h00, MODE_ALLGT);
    lit_q = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFF};
    pin_model("model_allgt");
    check("model_allgt_found", 32'(exp_found), 32'd0);

    run_search(8'h5A, MODE_KEY,     0, 1'b0,  9, "key5a");
    check("key5a_result_lit", 32'(result), 32'h5A);
    run_search(8'hFF, MODE_KEY,     0, 1'b0, 10, "keyff");
    check("keyff_result_lit", 32'(result), 32'hFF);
    run_search(8'h00, MODE_KEY,     0, 1'b0,  9, "key00");
    check("key00_found_lit", 32'(found), 32'd1);
    run_search(8'h33, MODE_ALLGT,   0, 1'b0, 10, "allgt");
    check("allgt_found_lit", 32'(found), 32'd0);
    run_search(8'h5A, MODE_KEY,     3, 1'b1, 33, "wait5a");
    check("wait5a_result_lit", 32'(result), 32'h5A);
    run_search(8'h5A, MODE_ILLEGAL, 0, 1'b0,  3, "illegal");
    check("illegal_err_lit", 32'(err), 32'd1);

    // Reset in the middle of a search, while probe 4 (0x4F) is presented.
    key = 8'h5A; mode = MODE_KEY; wait_cycles = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_probe4", 32'(probe), 32'h4F);
    check("midrst_pv", 32'(probe_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_probe", 32'(probe), 32'd0);
    check("midrst_pv0", 32'(probe_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_found", 32'(found), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || probe_valid) dcount++;
    end
    check("midrst_quiet", 32'(dcount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
